// File: rtl/communication_receive_pkg.sv
// ============================================================================
//  Module      : communication_receive_pkg
//  Description : Shared definitions for the serial link receiver: receiver
//                state encoding, frame geometry, line idle level and the
//                parity function also used by the transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package communication_receive_pkg;

   localparam int DATA_BITS = 8;

   // Level the sd line rests at between frames.
   localparam logic LINE_IDLE = 1'b1;

   // Receiver state encoding
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   // Parity bit the transmitter appends so that XOR(data, parity) == odd.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] i_d,
                                       input logic                 i_odd);
      return (^i_d) ^ i_odd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/communication_receive_sync2.sv
// ============================================================================
//  Module      : comm_sync2
//  Description : Two-flop synchronizer with a selectable reset level.
//  Ports       : i_clk   - destination clock
//                i_rst_n - asynchronous active-low reset
//                i_d     - asynchronous input
//                o_q     - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comm_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/communication_receive.sv
// ============================================================================
//  Module      : communication_receive
//  Description : Serial-frame receiver. Recovers start/8 data (LSB first)/
//                optional parity/stop frames on i_sd by mid-bit sampling,
//                checks parity and framing, and holds each byte with a sticky
//                valid flag until acknowledged on i_rd.
//  Ports       : i_clk1        - clock (rising edge)
//                i_rst_n       - asynchronous active-low reset
//                i_sd          - serial line, idles high
//                i_rec_en      - frame enable, 0 = line ignored
//                i_rd          - one-cycle acknowledge
//                o_data        - last received byte
//                o_data_valid  - byte not yet acknowledged
//                o_parity_err  - parity mismatch on o_data
//                o_frame_err   - stop bit was 0 on o_data
//                o_overrun     - unacknowledged byte was overwritten
//                o_busy        - receiver not idle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module communication_receive
   import communication_receive_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_clk1,
   input  logic                 i_rst_n,
   input  logic                 i_sd,
   input  logic                 i_rec_en,
   input  logic                 i_rd,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_data_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam logic [7:0] C_CPB  = 8'(CLKS_PER_BIT);
   localparam logic [7:0] C_HALF = 8'(CLKS_PER_BIT / 2);
   localparam logic       C_ODD  = (PARITY_ODD != 0);

   logic                 w_sd_s;
   logic                 w_en_s;
   logic                 w_tick;
   logic                 w_stop_sample;

   logic [2:0]           r_state;
   logic [7:0]           r_cnt;
   logic [3:0]           r_bitcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_err;

   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_overrun;

   comm_sync2 #(.RST_VAL(LINE_IDLE)) u_sync_sd (
      .i_clk   (i_clk1),
      .i_rst_n (i_rst_n),
      .i_d     (i_sd),
      .o_q     (w_sd_s)
   );

   comm_sync2 #(.RST_VAL(1'b0)) u_sync_en (
      .i_clk   (i_clk1),
      .i_rst_n (i_rst_n),
      .i_d     (i_rec_en),
      .o_q     (w_en_s)
   );

   // The sample counter restarts at 1 on every sample edge so that the
   // next sample lands exactly CLKS_PER_BIT edges later.
   assign w_tick        = (r_cnt == C_CPB);
   assign w_stop_sample = (r_state == S_STOP) && w_en_s && w_tick;

   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_bitcnt  <= 4'd0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt     <= 8'd1;
               r_bitcnt  <= 4'd0;
               r_par_err <= 1'b0;
               if (w_en_s && (w_sd_s == 1'b0)) begin
                  // With HALF = 0 the detection edge is the start sample.
                  if (C_HALF == 8'd0)
                     r_state <= S_DATA;
                  else
                     r_state <= S_START;
               end
            end

            S_START: begin
               if (!w_en_s) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == C_HALF) begin
                  r_cnt   <= 8'd1;
                  r_state <= w_sd_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_DATA: begin
               if (!w_en_s) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_cnt    <= 8'd1;
                  r_shift  <= {w_sd_s, r_shift[DATA_BITS-1:1]};
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'(DATA_BITS - 1))
                     r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_PARITY: begin
               if (!w_en_s) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_cnt     <= 8'd1;
                  r_par_err <= (w_sd_s != parity_bit(r_shift, C_ODD));
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_STOP: begin
               if (!w_en_s) begin
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  r_cnt   <= 8'd1;
                  // A low stop bit means the line may be held in break;
                  // wait for it to return high before re-arming.
                  r_state <= w_sd_s ? S_IDLE : S_BREAK;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_BREAK: begin
               if (w_sd_s)
                  r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Holding register and handshake flags.
   always_ff @(posedge i_clk1 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_stop_sample) begin
         r_data  <= r_shift;
         r_perr  <= r_par_err;
         r_ferr  <= ~w_sd_s;
         r_valid <= 1'b1;
         // An ack arriving with the new byte consumes the old one.
         if (i_rd)
            r_overrun <= 1'b0;
         else if (r_valid)
            r_overrun <= 1'b1;
      end else if (i_rd) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

   assign o_data       = r_data;
   assign o_data_valid = r_valid;
   assign o_parity_err = r_perr;
   assign o_frame_err  = r_ferr;
   assign o_overrun    = r_overrun;
   assign o_busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_communication_receive.sv
// ============================================================================
//  Module      : tb_communication_receive
//  Description : Directed self-checking bench for communication_receive.
//                dut0 uses default parameters, dut1 uses CLKS_PER_BIT = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_communication_receive;

   logic       clk;
   logic       rst_n;
   logic       sd0;
   logic       sd1;
   logic       rec_en;
   logic       rd;

   logic [7:0] data0;
   logic       valid0, perr0, ferr0, ovr0, busy0;
   logic [7:0] data1;
   logic       valid1, perr1, ferr1, ovr1, busy1;

   int total = 0;
   int bad   = 0;

   communication_receive dut0 (
      .i_clk1       (clk),
      .i_rst_n      (rst_n),
      .i_sd         (sd0),
      .i_rec_en     (rec_en),
      .i_rd         (rd),
      .o_data       (data0),
      .o_data_valid (valid0),
      .o_parity_err (perr0),
      .o_frame_err  (ferr0),
      .o_overrun    (ovr0),
      .o_busy       (busy0)
   );

   communication_receive #(.CLKS_PER_BIT(1)) dut1 (
      .i_clk1       (clk),
      .i_rst_n      (rst_n),
      .i_sd         (sd1),
      .i_rec_en     (rec_en),
      .i_rd         (rd),
      .o_data       (data1),
      .o_data_valid (valid1),
      .o_parity_err (perr1),
      .o_frame_err  (ferr1),
      .o_overrun    (ovr1),
      .o_busy       (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one frame starting at the current negedge; each bit is held for
   // cpb cycles. The line is left at the stop-bit level afterwards.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                             input int cpb, input bit sel);
      logic [10:0] bits;
      bits = {stop, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (sel) sd1 = bits[i];
         else     sd0 = bits[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sd0 = 1'b1; sd1 = 1'b1; rec_en = 1'b0; rd = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (data0  !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data0); end
      total++; if (valid0 !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", valid0); end
      total++; if (perr0  !== 1'b0)  begin bad++; $display("FAIL reset_perr got=%b exp=0", perr0); end
      total++; if (ferr0  !== 1'b0)  begin bad++; $display("FAIL reset_ferr got=%b exp=0", ferr0); end
      total++; if (ovr0   !== 1'b0)  begin bad++; $display("FAIL reset_overrun got=%b exp=0", ovr0); end
      total++; if (busy0  !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      total++; if (busy1  !== 1'b0)  begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
      rec_en = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0);
      // One cycle before the stop edge (E+43): nothing delivered yet.
      total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b exp=0", valid0); end
      total++; if (busy0  !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy0); end
      @(negedge clk);
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL basic_valid got=%b exp=1", valid0); end
      total++; if (data0  !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", data0); end
      total++; if (perr0  !== 1'b0)  begin bad++; $display("FAIL basic_perr got=%b exp=0", perr0); end
      total++; if (ferr0  !== 1'b0)  begin bad++; $display("FAIL basic_ferr got=%b exp=0", ferr0); end
      total++; if (busy0  !== 1'b0)  begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy0); end
      pulse_rd();
      total++; if (valid0 !== 1'b0)  begin bad++; $display("FAIL basic_rd_valid got=%b exp=0", valid0); end
   endtask

   task automatic test_parity();
      send_frame(8'h07, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      total++; if (data0 !== 8'h07) begin bad++; $display("FAIL par_data got=%h exp=07", data0); end
      total++; if (perr0 !== 1'b1)  begin bad++; $display("FAIL par_err got=%b exp=1", perr0); end
      pulse_rd();
      send_frame(8'h07, 1'b1, 1'b1, 4, 1'b0);
      @(negedge clk);
      total++; if (perr0  !== 1'b0) begin bad++; $display("FAIL par_clear got=%b exp=0", perr0); end
      total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL par_valid got=%b exp=1", valid0); end
      pulse_rd();
   endtask

   task automatic test_glitch();
      sd0 = 1'b0;
      @(negedge clk);
      sd0 = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", busy0); end
      repeat (2) @(negedge clk);
      total++; if (busy0  !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", busy0); end
      total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", valid0); end
      repeat (3) @(negedge clk);
      send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      total++; if (data0  !== 8'h3C) begin bad++; $display("FAIL glitch_next_data got=%h exp=3c", data0); end
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL glitch_next_valid got=%b exp=1", valid0); end
      pulse_rd();
   endtask

   task automatic test_overrun();
      send_frame(8'h11, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      send_frame(8'h22, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      total++; if (data0  !== 8'h22) begin bad++; $display("FAIL ovr_data got=%h exp=22", data0); end
      total++; if (ovr0   !== 1'b1)  begin bad++; $display("FAIL ovr_set got=%b exp=1", ovr0); end
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL ovr_valid got=%b exp=1", valid0); end
      pulse_rd();
      total++; if (valid0 !== 1'b0)  begin bad++; $display("FAIL ovr_rd_valid got=%b exp=0", valid0); end
      total++; if (ovr0   !== 1'b0)  begin bad++; $display("FAIL ovr_rd_clear got=%b exp=0", ovr0); end
      // Second pass: ack lands on the same edge as the second stop sample.
      send_frame(8'h11, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      send_frame(8'h22, 1'b0, 1'b1, 4, 1'b0);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      total++; if (ovr0   !== 1'b0)  begin bad++; $display("FAIL ovr_coinc_ovr got=%b exp=0", ovr0); end
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL ovr_coinc_valid got=%b exp=1", valid0); end
      total++; if (data0  !== 8'h22) begin bad++; $display("FAIL ovr_coinc_data got=%h exp=22", data0); end
      pulse_rd();
   endtask

   task automatic test_break();
      send_frame(8'h81, 1'b0, 1'b0, 4, 1'b0);
      @(negedge clk);
      total++; if (ferr0  !== 1'b1)  begin bad++; $display("FAIL brk_ferr got=%b exp=1", ferr0); end
      total++; if (data0  !== 8'h81) begin bad++; $display("FAIL brk_data got=%h exp=81", data0); end
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL brk_valid got=%b exp=1", valid0); end
      pulse_rd();
      repeat (18) @(negedge clk);
      total++; if (busy0  !== 1'b1) begin bad++; $display("FAIL brk_busy_hold got=%b exp=1", busy0); end
      total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL brk_no_retrigger got=%b exp=0", valid0); end
      sd0 = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL brk_exit got=%b exp=0", busy0); end
      repeat (4) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b0);
      @(negedge clk);
      total++; if (ferr0 !== 1'b0)  begin bad++; $display("FAIL brk_next_ferr got=%b exp=0", ferr0); end
      total++; if (data0 !== 8'h5A) begin bad++; $display("FAIL brk_next_data got=%h exp=5a", data0); end
   endtask

   task automatic test_abort_reset();
      logic [10:0] fr;
      // 0x5A stays unacknowledged so the abort can be seen to preserve it.
      fr = {1'b1, 1'b0, 8'h96, 1'b0};
      for (int i = 0; i < 5; i++) begin
         sd0 = fr[i];
         repeat (4) @(negedge clk);
      end
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy0); end
      rec_en = 1'b0;
      sd0    = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (busy0  !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b exp=0", busy0); end
      total++; if (data0  !== 8'h5A) begin bad++; $display("FAIL abort_data got=%h exp=5a", data0); end
      total++; if (valid0 !== 1'b1)  begin bad++; $display("FAIL abort_valid got=%b exp=1", valid0); end
      total++; if (ferr0  !== 1'b0)  begin bad++; $display("FAIL abort_ferr got=%b exp=0", ferr0); end
      rec_en = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sd0 = fr[i];
         repeat (4) @(negedge clk);
      end
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rst_busy_before got=%b exp=1", busy0); end
      rst_n = 1'b0;
      #1;
      total++; if (busy0  !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", busy0); end
      total++; if (data0  !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data0); end
      total++; if (valid0 !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%b exp=0", valid0); end
      total++; if (perr0  !== 1'b0)  begin bad++; $display("FAIL rst_perr got=%b exp=0", perr0); end
      total++; if (ovr0   !== 1'b0)  begin bad++; $display("FAIL rst_overrun got=%b exp=0", ovr0); end
      sd0 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      fork
         begin
            send_frame(8'hFF, 1'b0, 1'b1, 1, 1'b1);
            send_frame(8'h00, 1'b0, 1'b1, 1, 1'b1);
         end
         begin
            repeat (13) @(negedge clk);
            total++; if (data1  !== 8'hFF) begin bad++; $display("FAIL b2b_first_data got=%h exp=ff", data1); end
            total++; if (valid1 !== 1'b1)  begin bad++; $display("FAIL b2b_first_valid got=%b exp=1", valid1); end
         end
      join
      repeat (2) @(negedge clk);
      total++; if (data1  !== 8'h00) begin bad++; $display("FAIL b2b_second_data got=%h exp=00", data1); end
      total++; if (valid1 !== 1'b1)  begin bad++; $display("FAIL b2b_valid got=%b exp=1", valid1); end
      total++; if (ovr1   !== 1'b1)  begin bad++; $display("FAIL b2b_overrun got=%b exp=1", ovr1); end
      total++; if (perr1  !== 1'b0)  begin bad++; $display("FAIL b2b_perr got=%b exp=0", perr1); end
      total++; if (ferr1  !== 1'b0)  begin bad++; $display("FAIL b2b_ferr got=%b exp=0", ferr1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_glitch();
      test_overrun();
      test_break();
      test_abort_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/communication_receive.md
# communication_receive

Serial-frame receiver for the link driven by the team's serial transmitter block. Recovers the sd line (start bit 0, 8 data bits LSB first, optional parity, stop bit 1) by mid-bit sampling on clk1, checks parity and framing, and presents each byte in a holding register with a sticky valid flag until the consumer acknowledges it. It sits at the receiving end of the link, feeding the local controller.

## Interface
- CLKS_PER_BIT, 4: clk1 cycles per bit period; legal range 1..255. HALF = floor(CLKS_PER_BIT/2).
- PARITY_EN, 1: 1 = a parity bit follows data bit 7; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, meaning XOR of data and parity bits is 0; 1 = odd parity.
- clk1  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sd  in  1  serial line; idles at 1.
- rec_en  in  1  frame enable from the far end; 0 = line ignored.
- rd  in  1  one-cycle acknowledge; clears data_valid and overrun.
- data  out  8  last received byte.
- data_valid  out  1  byte in data not yet acknowledged.
- parity_err  out  1  parity mismatch on the byte in data.
- frame_err  out  1  stop bit sampled 0 on the byte in data.
- overrun  out  1  sticky; an unacknowledged byte was overwritten.
- busy  out  1  high in every state except IDLE.

## Operation
- sd and rec_en each pass through a 2-flop synchronizer, giving sd_s and en_s; all decisions use these.
- States and transitions:
  - IDLE: goes to START when en_s=1 and sd_s=0; clears bit counter and sample counter.
  - START: samples sd_s at sample count HALF. Sampled 1 is a glitch and returns to IDLE. Sampled 0 goes to DATA.
  - DATA: samples every CLKS_PER_BIT cycles after the start sample. Shifts bits in LSB first. After bit 7 goes to PARITY, or to STOP when PARITY_EN=0.
  - PARITY: one sample; computes the mismatch.
  - STOP: one sample, then updates outputs. Stop sampled 1 goes to IDLE; stop sampled 0 goes to BREAK.
  - BREAK: waits until sd_s=1, then goes to IDLE. A held-low line never retriggers reception.
- Output update at the stop-sample edge:
  - data <= shift register; parity_err and frame_err <= this frame's results; data_valid <= 1.
  - A byte with an error is still delivered with its flags.
- Handshake and overrun:
  - rd=1 with no frame completing: data_valid <= 0, overrun <= 0.
  - Frame completes while data_valid=1 and rd=0: new byte overwrites data and overrun <= 1.
  - Frame completes in the same cycle as rd=1: new byte loads, data_valid stays 1, overrun <= 0.
- en_s falling mid-frame aborts to IDLE at the next edge. data and all flags are left unchanged.
- Asynchronous reset mid-frame returns to IDLE immediately.
- Counter widths: sample counter 8 bits, bit counter 4 bits. Parity is an XOR reduction over 8 data bits plus the parity bit.

## Timing
- Reset values: data=8'h00; data_valid, parity_err, frame_err, overrun, busy = 0; state IDLE; synchronizer flops = 1 for sd, 0 for rec_en.
- Edge E is the first clk1 edge that samples sd=0 with rec_en stable high. Detection happens at edge E+2.
- Sample edges after detection:
  - start: E+2+HALF
  - data bit k: E+2+HALF+(k+1)·CLKS_PER_BIT
  - parity: E+2+HALF+9·CLKS_PER_BIT
  - stop: E+2+HALF+(9+PARITY_EN)·CLKS_PER_BIT
- data_valid is visible right after the stop edge. With default parameters that is 44 cycles after E.
- CLKS_PER_BIT=1 gives HALF=0: the start sample is taken at the detection edge. Back-to-back frames, with no idle between the stop bit and the next start bit, are received without loss.
- busy rises at edge E+2 and falls at the stop edge. When the stop bit is 0, busy instead falls when BREAK exits.

## Structure
- Shared package holds: the state encoding (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=8, the line idle level, and a parity function shared with the transmitter.
- One sub-module, comm_sync2: a 2-flop synchronizer with a reset value parameter. It is instantiated for sd and rec_en.

## Test plan
- Defaults, frame 0xA5 with parity 0 and stop 1 → data=8'hA5, data_valid rises 44 cycles after E, parity_err=0, frame_err=0.
- Frame 0x07 with parity bit flipped to 0 → data=8'h07, parity_err=1. A following clean frame 0x07 with parity 1 clears parity_err.
- Low pulse on sd of 1 cycle in IDLE → START rejects it, busy returns to 0, data_valid stays 0. A 0x3C frame sent afterwards is received correctly.
- Two frames 0x11 then 0x22 with no rd → data=8'h22, overrun=1. Assert rd → data_valid=0, overrun=0. Repeat with rd coinciding with the second stop edge → overrun=0, data_valid=1.
- Stop bit 0 followed by 20 cycles of sd held low → frame_err=1, busy stays 1 in BREAK, no second frame starts. sd returns high, then frame 0x5A → frame_err=0.
- rec_en dropped after data bit 3, then rst_n pulsed mid-frame in a second attempt → no output change on the abort, all outputs reset values after rst_n, and CLKS_PER_BIT=1 back-to-back frames 0xFF then 0x00 are both received.
